// File: rtl/sssp_relax_engine.sv
// sssp_relax_engine: multi-lane SSSP edge relaxation pipeline with run-control FSM.
// Define SSSP_STATS_EN to add the edges_seen / updates_emitted counters.
module sssp_relax_engine #(
  parameter int ADDR_W = 8,
  parameter int LANES = 4,
  parameter int LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            control,
  input  logic                  mode,
  input  logic [15:0]           current_level,
  input  logic [511:0]          word_in,
  input  logic [31:0]           w_addr,
  input  logic                  word_in_valid,
  input  logic                  last_input_in,
  output logic [64*LANES-1:0]   word_out,
  output logic [LANES-1:0]      valid_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef SSSP_STATS_EN
  ,
  output logic [31:0]           edges_seen,
  output logic [31:0]           updates_emitted
`endif
);
  localparam int ROWS = 2 ** (ADDR_W - 3);
  localparam int CW = $clog2(LAT);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31-ADDR_W:0] pfx;
  logic pfx_set, load_acc, edge_acc, bad;
  logic m0, m1;
  logic [15:0] lvl0, lvl1;
  logic unused;
  assign unused = ^{word_in, w_addr[2:0]};
  always_comb begin
    load_acc = word_in_valid && control == 2'd1 && (state == IDLE || state == LOAD);
    edge_acc = word_in_valid && (state == RUN ? (control == 2'd0 || control == 2'd2)
                                              : (control == 2'd2 && state != DRAIN));
    bad = control == 2'd3
       || (word_in_valid && (state == DRAIN || (state == RUN && control == 2'd1)))
       || (load_acc && pfx_set && w_addr[31:ADDR_W] != pfx);
    state_n = control == 2'd3 ? state
            : edge_acc && last_input_in ? DRAIN
            : state == IDLE ? (control == 2'd1 ? LOAD : control == 2'd2 ? RUN : IDLE)
            : state == LOAD ? (control == 2'd2 ? RUN : control == 2'd0 ? IDLE : LOAD)
            : state == DRAIN && cnt == CW'(LAT - 1) ? IDLE : state;
  end
  assign busy = state != IDLE;
  assign done = state == DRAIN && cnt == CW'(LAT - 1);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      pfx <= '0;
      pfx_set <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == DRAIN ? cnt + 1'b1 : '0;
      err <= err | bad;
      if (load_acc) begin
        pfx <= w_addr[31:ADDR_W];
        pfx_set <= 1'b1;
      end else if (state != LOAD) pfx_set <= 1'b0;
    end
  always_ff @(posedge clk) begin
    m0 <= mode;
    m1 <= m0;
    lvl0 <= current_level;
    lvl1 <= lvl0;
  end
  // Each lane's vertex copy is split into 8 banks so a whole aligned line writes in one cycle.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [47:0] mem [8][ROWS];
    logic [47:0] rdb [8];
    logic [47:0] rd1;
    logic [2:0] bsel;
    logic [31:0] src, dst0, dst1, w0, w1, dist2, dst2;
    logic [32:0] sum;
    logic v0, v1, v2, hit, vo;
    logic [63:0] wo;
    assign src = word_in[i*128 +: 32];
    assign sum = {1'b0, rd1[31:0]} + {1'b0, w1};
    assign hit = v1 && (m1 ? rd1[31:0] != '1 : rd1[47:32] == lvl1);
    assign valid_out[i] = vo;
    assign word_out[i*64 +: 64] = wo;
    always_ff @(posedge clk) begin
      for (int k = 0; k < 8; k++) begin
        if (load_acc) mem[k][w_addr[ADDR_W-1:3]] <= word_in[k*64 +: 48];
        rdb[k] <= mem[k][src[ADDR_W-1:3]];
      end
      bsel <= src[2:0];
      rd1 <= rdb[bsel];
      dst0 <= word_in[i*128+32 +: 32];
      dst1 <= dst0;
      w0 <= word_in[i*128+64 +: 32];
      w1 <= w0;
      dist2 <= sum[32] ? '1 : sum[31:0];
      dst2 <= dst1;
    end
    always_ff @(posedge clk)
      if (rst) {v0, v1, v2, vo, wo} <= '0;
      else begin
        v0 <= edge_acc && src[31:ADDR_W] == pfx && src != word_in[i*128+32 +: 32];
        v1 <= v0;
        v2 <= hit;
        vo <= v2;
        wo <= v2 ? {dist2, dst2} : '0;
      end
  end
`ifdef SSSP_STATS_EN
  logic [31:0] pop;
  always_comb begin
    pop = '0;
    for (int j = 0; j < LANES; j++) pop = pop + 32'(valid_out[j]);
  end
  always_ff @(posedge clk)
    if (rst || (state == IDLE && state_n == LOAD)) begin
      edges_seen <= '0;
      updates_emitted <= '0;
    end else begin
      edges_seen <= edges_seen + (edge_acc ? 32'(LANES) : 32'd0);
      updates_emitted <= updates_emitted + pop;
    end
`endif
endmodule

// File: tb/tb_sssp_relax_engine.sv
// tb_sssp_relax_engine: directed and randomized checks of sssp_relax_engine against a vertex-table model.
module tb_sssp_relax_engine;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] control = '0;
  logic mode = 1'b0;
  logic [15:0] current_level = '0;
  logic [511:0] word_in = '0;
  logic [31:0] w_addr = '0;
  logic word_in_valid = 1'b0, last_input_in = 1'b0;
  logic [255:0] word_out;
  logic [3:0] valid_out;
  logic busy, done, err;

  always #5 clk = ~clk;

  sssp_relax_engine dut (
    .clk(clk), .rst(rst), .control(control), .mode(mode), .current_level(current_level),
    .word_in(word_in), .w_addr(w_addr), .word_in_valid(word_in_valid),
    .last_input_in(last_input_in), .word_out(word_out), .valid_out(valid_out),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {logic [3:0] v; logic [255:0] w;} exp_t;
  exp_t q[$];
  logic [31:0] vdist [256];
  logic [15:0] vlev [256];
  logic [23:0] m_pfx = '0;
  logic [23:0] pfx;
  logic [511:0] ln, ln2, wi;
  logic [31:0] s, d;
  bit v;
  int n_asrt = 0, n_fail = 0, emitted = 0;

  function automatic logic [127:0] mk_edge(input logic [31:0] src, dst, w);
    return {32'($urandom()), w, dst, src};
  endfunction

  function automatic logic [511:0] rand_line(input bit special);
    logic [511:0] r;
    logic [31:0] dd;
    for (int k = 0; k < 8; k++) begin
      dd = $urandom();
      if (!special) dd = dd & 32'h7FFFFFFF;
      else if ($urandom_range(0, 5) == 0) dd = 32'hFFFFFFFF;
      else if ($urandom_range(0, 4) == 0) dd = 32'hFFFFFF00 | 32'($urandom_range(0, 255));
      r[k*64 +: 64] = {16'($urandom()), 16'($urandom_range(0, 3)), dd};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    e = q.pop_front();
    emitted += $countones(valid_out);
    chk("valid_out", 256'(valid_out), 256'(e.v));
    chk("word_out", word_out, e.w);
  endtask

  // Applies one beat for one cycle; the model predicts what that beat shows four cycles later.
  task automatic drive(input logic [1:0] c, input logic vl, input logic lst,
                       input logic [511:0] win, input logic [31:0] a, input bit acc);
    exp_t e;
    logic [31:0] sr, ds, wt, vd;
    logic [63:0] sum;
    logic [7:0] idx;
    e = '0;
    control = c; word_in_valid = vl; last_input_in = lst; word_in = win; w_addr = a;
    if (vl && acc && c == 2'd2)
      for (int i = 0; i < 4; i++) begin
        sr = win[i*128 +: 32]; ds = win[i*128+32 +: 32]; wt = win[i*128+64 +: 32];
        vd = vdist[sr[7:0]];
        if (sr[31:8] == m_pfx && sr != ds &&
            (mode ? vd != 32'hFFFFFFFF : vlev[sr[7:0]] == current_level)) begin
          sum = {32'd0, vd} + {32'd0, wt};
          e.v[i] = 1'b1;
          e.w[i*64 +: 64] = {(sum > 64'hFFFFFFFF) ? 32'hFFFFFFFF : sum[31:0], ds};
        end
      end
    if (vl && acc && c == 2'd1) begin
      for (int k = 0; k < 8; k++) begin
        idx = a[7:0] + 8'(k);
        vdist[idx] = win[k*64 +: 32];
        vlev[idx] = win[k*64+32 +: 16];
      end
      m_pfx = a[31:8];
    end
    q.push_back(e);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'd0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic reset();
    rst = 1'b1; control = '0; word_in_valid = 1'b0; last_input_in = 1'b0;
    word_in = '0; w_addr = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pfx = '0;
    q.delete();
    repeat (3) q.push_back('0);
    chk("rst_word", word_out, '0);
    chk("rst_valid", 256'(valid_out), '0);
    chk("rst_busy", 256'(busy), '0);
    chk("rst_done", 256'(done), '0);
    chk("rst_err", 256'(err), '0);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin vdist[k] = '0; vlev[k] = '0; end
    reset();
    ln = rand_line(0);
    ln[3*64 +: 48] = {16'd2, 32'd10};
    drive(2'd1, 1'b1, 1'b0, ln, 32'h1200, 1'b1);
    mode = 1'b0; current_level = 16'd2;
    wi = '0; wi[127:0] = mk_edge(32'h1203, 32'h50, 32'd5);
    drive(2'd2, 1'b1, 1'b1, wi, '0, 1'b1);
    chk("t1_busy", 256'(busy), 256'(1));
    idle(2);
    chk("t1_done_early", 256'(done), '0);
    idle(1);
    chk("t1_word", 256'(word_out[63:0]), 256'({32'd15, 32'h50}));
    chk("t1_done", 256'(done), 256'(1));
    idle(1);
    chk("t1_busy_end", 256'(busy), '0);
    chk("t1_done_end", 256'(done), '0);

    wi = '0;
    wi[0*128 +: 128] = mk_edge(32'h1203, 32'h50, 32'd5);
    wi[1*128 +: 128] = mk_edge(32'h1303, 32'h60, 32'd1);
    wi[2*128 +: 128] = mk_edge(32'h1203, 32'h1203, 32'd1);
    wi[3*128 +: 128] = mk_edge(32'h1203, 32'h70, 32'hFFFFFFFF);
    drive(2'd2, 1'b1, 1'b1, wi, '0, 1'b1);
    idle(3);
    chk("t2_lanes12", 256'(valid_out[2:1]), '0);
    chk("t2_sat", 256'(word_out[255:192]), 256'({32'hFFFFFFFF, 32'h70}));
    chk("t2_done", 256'(done), 256'(1));
    idle(1);

    ln = rand_line(0);
    ln[0 +: 32] = 32'hFFFFFFF0;
    ln[64 +: 32] = 32'hFFFFFFFF;
    drive(2'd1, 1'b1, 1'b0, ln, 32'h1200, 1'b1);
    mode = 1'b1;
    wi = '0;
    wi[0*128 +: 128] = mk_edge(32'h1200, 32'h1, 32'h20);
    wi[1*128 +: 128] = mk_edge(32'h1201, 32'h2, 32'h1);
    drive(2'd2, 1'b1, 1'b1, wi, '0, 1'b1);
    idle(3);
    chk("t3_valid", 256'(valid_out), 256'(4'b0001));
    chk("t3_sat", 256'(word_out[63:0]), 256'({32'hFFFFFFFF, 32'h1}));
    idle(1);

    for (int j = 0; j < 32; j++) drive(2'd1, 1'b1, 1'b0, rand_line(0), 32'h3400 + 32'(8 * j), 1'b1);
    mode = 1'b1;
    emitted = 0;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 4; i++) begin
        s = {24'h34, 8'($urandom())};
        wi[i*128 +: 128] = mk_edge(s, s ^ 32'h80000000, $urandom());
      end
      drive(2'd2, 1'b1, j == 7, wi, '0, 1'b1);
    end
    idle(3);
    chk("b2b_done", 256'(done), 256'(1));
    idle(1);
    chk("b2b_count", 256'(emitted), 256'(32));

    repeat (3) begin
      pfx = 24'($urandom());
      for (int j = 0; j < 32; j++) drive(2'd1, 1'b1, 1'b0, rand_line(1), {pfx, 8'(8 * j)}, 1'b1);
      for (int j = 0; j < 16; j++) begin
        v = j == 15 || $urandom_range(0, 3) != 0;
        mode = 1'($urandom_range(0, 1));
        current_level = 16'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) begin
          s = $urandom_range(0, 7) == 0 ? $urandom() : {pfx, 8'($urandom())};
          d = $urandom_range(0, 5) == 0 ? s : $urandom();
          wi[i*128 +: 128] = mk_edge(s, d, $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 100)));
        end
        drive(2'd2, v, j == 15, wi, '0, v);
      end
      idle(3);
      chk("rnd_done", 256'(done), 256'(1));
      idle(1);
      chk("rnd_busy", 256'(busy), '0);
    end

    chk("err_clean", 256'(err), '0);
    mode = 1'b0; current_level = 16'd2;
    wi = '0; wi[127:0] = mk_edge(32'h1203, 32'h50, 32'd5);
    drive(2'd2, 1'b1, 1'b1, wi, '0, 1'b1);
    drive(2'd1, 1'b1, 1'b0, rand_line(0), 32'h1200, 1'b0);
    chk("err_drain", 256'(err), 256'(1));
    idle(2);
    chk("err_done", 256'(done), 256'(1));
    idle(1);
    chk("err_sticky", 256'(err), 256'(1));
    reset();
    drive(2'd3, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("err_ctrl3", 256'(err), 256'(1));
    chk("ctrl3_busy", 256'(busy), '0);
    reset();
    ln = rand_line(0);
    ln2 = rand_line(0);
    drive(2'd1, 1'b1, 1'b0, ln, 32'h1200, 1'b1);
    chk("pfx_same_ok", 256'(err), '0);
    drive(2'd1, 1'b1, 1'b0, ln2, 32'h5600, 1'b1);
    chk("err_pfx", 256'(err), 256'(1));
    idle(1);
    reset();

    ln = rand_line(0);
    ln[3*64 +: 48] = {16'd2, 32'd10};
    drive(2'd1, 1'b1, 1'b0, ln, 32'h1200, 1'b1);
    mode = 1'b0; current_level = 16'd2;
    wi = '0; wi[127:0] = mk_edge(32'h1203, 32'h50, 32'd5);
    drive(2'd2, 1'b1, 1'b0, wi, '0, 1'b1);
    drive(2'd2, 1'b0, 1'b0, '0, '0, 1'b0);
    reset();
    repeat (4) begin
      idle(1);
      chk("mid_rst_done", 256'(done), '0);
      chk("mid_rst_busy", 256'(busy), '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/sssp_relax_engine.md
Name: sssp_relax_engine

Overview:
Multi-lane successor to the single-lane SSSP edge pipeline. Loads a 2^ADDR_W-vertex slice into LANES private BRAM copies, then relaxes LANES edges per 512-bit input line in parallel, emitting (new_dist, dst) update candidates. Has an explicit run-control FSM with drain/done signalling, a selectable relax mode and saturating distance arithmetic. Sits between the AFU edge-read stream and the update write-back/merge logic.

Parameters:
ADDR_W, 8, log2 of vertex slice depth (vertices per slice).
LANES, 4, edges per input line processed in parallel; legal values 1, 2, 4; lane i uses word_in[i*128+127 : i*128].
LAT, 4, fixed input-to-output latency in cycles; only the value 4 is legal.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
control  in  2  0 = idle, 1 = load vertices, 2 = process edges, 3 = reserved
mode  in  1  0 = level-synchronous, 1 = distance relax
current_level  in  16  frontier level for mode 0
word_in  in  512  vertex line (load) or LANES packed edges (process)
w_addr  in  32  vertex index of the first vertex in the line; 8-aligned
word_in_valid  in  1  input beat valid
last_input_in  in  1  marks the final edge beat of a pass
word_out  out  64*LANES  per lane {dist[63:32], dst[31:0]}
valid_out  out  LANES  per-lane update valid
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse at the end of drain
err  out  1  sticky protocol error

Behaviour:
- Edge format (128 b): [31:0] src, [63:32] dst, [95:64] weight, [127:96] ignored.
- Vertex format (64 b, 8 per line): [31:0] dist, [47:32] level, [63:48] ignored. Vertex k of a line is written to BRAM address w_addr[ADDR_W-1:0] + k. All LANES copies are written identically.
- Prefix: w_addr[31:ADDR_W] is latched on every load beat. A load beat whose prefix differs from the first load beat of the same LOAD phase sets err.
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - IDLE -> LOAD on control == 1.
  - IDLE or LOAD -> RUN on control == 2.
  - LOAD -> IDLE on control == 0.
  - RUN -> DRAIN when a beat with word_in_valid & last_input_in is accepted.
  - DRAIN counts LAT cycles, then pulses done and returns to IDLE.
  - control == 3 in any state sets err; the state is unchanged.
- Input acceptance:
  - Load beats are accepted only in LOAD (or IDLE with control == 1).
  - Edge beats are accepted only in RUN (or IDLE/LOAD with control == 2).
  - A beat with word_in_valid in DRAIN, or a load beat in RUN, is ignored and sets err.
- Per lane, an accepted edge at cycle T produces its output at cycle T+4:
  - T+1, T+2: BRAM read of src.
  - T+3: compare/add registered.
  - T+4: output registered.
- Emit condition, all required:
  - edge accepted;
  - src[31:ADDR_W] == latched prefix;
  - src != dst;
  - mode 0: vertex.level == current_level, where current_level is sampled at T;
  - mode 1: vertex.dist != 32'hFFFFFFFF.
- new_dist = vertex.dist + weight as a 33-bit sum, saturated to 32'hFFFFFFFF on carry.
- valid_out[i] is low on any non-emitting cycle; word_out lanes are 0 when their valid is low.
- Read-during-write on the same BRAM address: returns old data; this case is not exercised in the protocol.
- Reset:
  - word_out = 0, valid_out = 0, busy = 0, done = 0, err = 0, FSM = IDLE.
  - Pipeline valids and prefix are cleared.
  - BRAM contents are not cleared.
- Reset mid-RUN or mid-DRAIN: in-flight edges are discarded and no done is produced.

Optional Feature:
SSSP_STATS_EN: adds 32-bit outputs edges_seen (count of accepted edge lanes, i.e. +LANES per beat) and updates_emitted (popcount of valid_out per cycle). Both counters clear on rst and on the IDLE -> LOAD transition, and wrap at 2^32. Without the macro these ports and counters do not exist.

Test Plan:
- Load 1 line at w_addr 0x1200 (ADDR_W = 8), vertex 3 = {dist 10, level 2}; RUN, mode 0, current_level 2; edge lane0 {src 0x1203, dst 0x50, w 5} with last_input_in -> valid_out[0] at T+4, word_out lane0 = {15, 0x50}; done 4 cycles after that beat; busy low afterwards.
- Same setup, lane1 src 0x1303 (prefix mismatch) and lane2 src == dst == 0x1203 -> valid_out[1] and valid_out[2] stay 0.
- Mode 1: vertex dist 0xFFFFFFF0, weight 0x20 -> word_out dist = 0xFFFFFFFF. Vertex dist 0xFFFFFFFF -> no emit.
- Back-to-back edge beats for 8 cycles on all 4 lanes -> 32 outputs on consecutive cycles, no bubbles, ordering preserved.
- Load beat with control 1 during DRAIN -> err = 1 and stays 1 until rst. control = 3 -> err = 1.
- Assert rst at T+2 after an emitting edge -> no valid_out, no done; FSM in IDLE; all outputs 0.
